// File: rtl/multi_path_fanin_pipeline_if.sv
// Handshake bundle for the three-lane fan-in pipeline: per-lane valid/ready/data
// in, a single valid/ready/data/src output, plus the completed-transfer counter.
interface multi_path_fanin_pipeline_if #(
    parameter int WIDTH = 8
);
    logic [2:0]         in_valid;
    logic [3*WIDTH-1:0] in_data;
    logic [2:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_src;
    logic               out_ready;
    logic [15:0]        out_count;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_src,
        input  out_count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_src,
        output out_count
    );
endinterface

// File: rtl/multi_path_fanin_pipeline.sv
// Three valid/ready lanes merged by a round-robin arbiter into an elastic
// STAGES-deep register pipeline with one valid/ready output and a transfer counter.
module multi_path_fanin_pipeline #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    multi_path_fanin_pipeline_if.slave   bus
);

    logic [WIDTH-1:0]  data_p [STAGES];
    logic [1:0]        src_p  [STAGES];
    logic [STAGES-1:0] vld_p;

    logic [WIDTH-1:0]  data_nx [STAGES];
    logic [1:0]        src_nx  [STAGES];
    logic [STAGES-1:0] vld_nx;
    logic [STAGES-1:0] can_acc;

    logic [1:0]        rr_ptr;
    logic [2:0]        grant;
    logic [1:0]        grant_idx;
    logic [WIDTH-1:0]  lane_data;
    logic              in_fire;
    logic              out_fire;
    logic [15:0]       out_count_q;

    function automatic logic [1:0] next_lane(input logic [1:0] lane);
        return (lane == 2'd2) ? 2'd0 : lane + 2'd1;
    endfunction

    // Search order ptr, ptr+1, ptr+2 (mod 3); first requesting lane wins.
    function automatic logic [2:0] rr_grant(input logic [2:0] req, input logic [1:0] ptr);
        logic [3:0] req_w;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       found;
        req_w = {1'b0, req};
        gnt   = '0;
        idx   = (ptr == 2'd3) ? 2'd0 : ptr;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!found && req_w[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
            idx = next_lane(idx);
        end
        return gnt[2:0];
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

    // A stage can accept if any stage from it to the output is empty, or the
    // output drains this cycle. This is the out_ready -> in_ready chain.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        can_acc   = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            full_tail  = full_tail & vld_p[s];
            can_acc[s] = ~full_tail | bus.out_ready;
        end
    end

    always_comb begin
        grant     = rr_grant(bus.in_valid, rr_ptr);
        grant_idx = onehot_to_idx(grant);
        lane_data = '0;
        for (int k = 0; k < 3; k++) begin
            if (grant[k]) lane_data = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    assign bus.in_ready = grant & {3{can_acc[0] & rst_n}};
    assign in_fire      = |(bus.in_valid & bus.in_ready);
    assign out_fire     = vld_p[STAGES-1] & bus.out_ready;

    // Inputs presented to each stage: stage 0 from the granted lane, others
    // from their predecessor.
    always_comb begin
        vld_nx     = '0;
        vld_nx[0]  = in_fire;
        data_nx[0] = lane_data;
        src_nx[0]  = grant_idx;
        for (int s = 1; s < STAGES; s++) begin
            vld_nx[s]  = vld_p[s-1];
            data_nx[s] = data_p[s-1];
            src_nx[s]  = src_p[s-1];
        end
    end

    // Stage registers: load on accept, otherwise hold; empty stages keep stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_p[s] <= '0;
                src_p[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (can_acc[s]) begin
                    vld_p[s] <= vld_nx[s];
                    if (vld_nx[s]) begin
                        data_p[s] <= data_nx[s];
                        src_p[s]  <= src_nx[s];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= 2'd0;
            out_count_q <= 16'd0;
        end else begin
            if (in_fire) rr_ptr <= next_lane(grant_idx);
            if (out_fire) out_count_q <= out_count_q + 16'd1;
        end
    end

    assign bus.out_valid = vld_p[STAGES-1];
    assign bus.out_data  = data_p[STAGES-1];
    assign bus.out_src   = src_p[STAGES-1];
    assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_multi_path_fanin_pipeline.sv
// Self-checking bench for multi_path_fanin_pipeline: scoreboard on every
// transfer plus table-driven arbitration vectors and hand-written corner cases.
module tb_multi_path_fanin_pipeline;
    localparam int W = 8;
    localparam int S = 3;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   src;
    } item_t;

    typedef struct {
        logic [2:0] vmask;
        logic [2:0] exp_rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multi_path_fanin_pipeline_if #(.WIDTH(W)) bus();

    multi_path_fanin_pipeline #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    item_t       exp_q[$];
    item_t       exp_item;
    logic [15:0] exp_count;
    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: push on accepted input, pop/compare on delivered output.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_count <= 16'd0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_underflow: got output %0h with empty scoreboard", bus.out_data);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(exp_item.data));
                    check("out_src", 32'(bus.out_src), 32'(exp_item.src));
                end
                exp_count <= exp_count + 16'd1;
            end
            for (int k = 0; k < 3; k++) begin
                if (bus.in_valid[k] && bus.in_ready[k])
                    exp_q.push_back({bus.in_data[k*W +: W], 2'(k)});
            end
            check("ready_onehot", 32'($countones(bus.in_ready) <= 1), 32'd1);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int cycles);
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        // Arbitration walk from pointer 0 with out_ready held high.
        vecs[0] = '{3'b111, 3'b001};
        vecs[1] = '{3'b101, 3'b100};
        vecs[2] = '{3'b110, 3'b010};
        vecs[3] = '{3'b011, 3'b001};
        vecs[4] = '{3'b001, 3'b001};
        vecs[5] = '{3'b100, 3'b100};
        vecs[6] = '{3'b010, 3'b010};
        vecs[7] = '{3'b111, 3'b100};

        rst_n         = 1'b0;
        bus.in_valid  = 3'b111;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_src", 32'(bus.out_src), 32'd0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);

        // Single lane latency.
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 3'b010;
        bus.in_data   = {8'h00, 8'h5A, 8'h00};
        #1 check("t1_ready", 32'(bus.in_ready), 32'b010);
        @(negedge clk);
        bus.in_valid = '0;
        check("t1_lat1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("t1_lat2", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("t1_lat3", 32'(bus.out_valid), 32'd1);
        check("t1_data", 32'(bus.out_data), 32'h5A);
        check("t1_src", 32'(bus.out_src), 32'd1);
        @(negedge clk);
        check("t1_count", 32'(bus.out_count), 32'd1);

        // All lanes contend, one item per cycle.
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 3'b111;
        for (int i = 0; i < 9; i++) begin
            bus.in_data = {8'(8'h20 + i), 8'(8'h10 + i), 8'(i)};
            #1;
            check("t2_grant", 32'(bus.in_ready), 32'(3'b001 << (i % 3)));
            check("t2_stream", 32'(bus.out_valid), 32'(i >= S));
            @(negedge clk);
        end
        drain(5);
        check("t2_count", 32'(bus.out_count), 32'd9);

        // Table-driven arbitration vectors.
        do_reset();
        bus.out_ready = 1'b1;
        foreach (vecs[i]) begin
            bus.in_valid = vecs[i].vmask;
            bus.in_data  = {8'(8'h80 + i*4 + 2), 8'(8'h80 + i*4 + 1), 8'(8'h80 + i*4)};
            #1 check("tv_ready", 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
            @(negedge clk);
        end
        drain(6);
        check("tv_count", 32'(bus.out_count), 32'd8);

        // Backpressure on lane 2.
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 3'b100;
        for (int v = 1; v <= 3; v++) begin
            bus.in_data = {8'(v), 16'h0};
            #1 check("t3_accept", 32'(bus.in_ready), 32'b100);
            @(negedge clk);
        end
        bus.in_data = {8'h04, 16'h0};
        #1 check("t3_full", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t3_hold_data", 32'(bus.out_data), 32'h01);
            check("t3_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1 check("t3_release", 32'(bus.in_ready), 32'b100);
        @(negedge clk);
        drain(6);
        check("t3_count", 32'(bus.out_count), 32'd4);

        // Bubble collapse behind a stalled head item.
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 3'b001;
        bus.in_data   = {16'h0, 8'hA0};
        @(negedge clk);
        bus.in_valid = '0;
        repeat (2) @(negedge clk);
        check("t4_head", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 3'b010;
        bus.in_data  = {8'h0, 8'hB1, 8'h0};
        #1 check("t4_fill1", 32'(bus.in_ready), 32'b010);
        @(negedge clk);
        bus.in_data = {8'h0, 8'hB2, 8'h0};
        #1 check("t4_fill2", 32'(bus.in_ready), 32'b010);
        @(negedge clk);
        bus.in_data = {8'h0, 8'hB3, 8'h0};
        #1 check("t4_full", 32'(bus.in_ready), 32'd0);
        check("t4_stable", 32'(bus.out_data), 32'hA0);
        bus.out_ready = 1'b1;
        #1 check("t4_same_cycle", 32'(bus.in_ready), 32'b010);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1 check("t4_refull", 32'(bus.in_ready), 32'd0);
        check("t4_next_head", 32'(bus.out_data), 32'hB1);
        @(negedge clk);
        drain(6);
        check("t4_count", 32'(bus.out_count), 32'd4);

        // Reset mid-flight, pointer left at lane 2 beforehand.
        bus.out_ready = 1'b0;
        bus.in_valid  = 3'b001;
        bus.in_data   = {8'h0, 8'h0, 8'hC0};
        @(negedge clk);
        bus.in_valid = 3'b010;
        bus.in_data  = {8'h0, 8'hC1, 8'h0};
        @(negedge clk);
        bus.in_valid = '0;
        @(negedge clk);
        check("t5_inflight", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 3'b101;
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid_drop", 32'(bus.out_valid), 32'd0);
        check("t5_count_clr", 32'(bus.out_count), 32'd0);
        check("t5_ready_rst", 32'(bus.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        bus.in_data = {8'hD2, 8'h0, 8'hD0};
        #1 check("t5_lane0_first", 32'(bus.in_ready), 32'b001);
        @(negedge clk);
        #1 check("t5_lane2_next", 32'(bus.in_ready), 32'b100);
        @(negedge clk);
        drain(6);
        check("t5_count", 32'(bus.out_count), 32'd2);

        // Counter wrap.
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 3'b001;
        for (int i = 0; i < 65535; i++) begin
            bus.in_data = {16'h0, 8'(i)};
            @(negedge clk);
        end
        drain(5);
        check("t6_ffff", 32'(bus.out_count), 32'hFFFF);
        bus.in_valid = 3'b001;
        @(negedge clk);
        drain(5);
        check("t6_wrap", 32'(bus.out_count), 32'h0000);
        bus.in_valid = 3'b001;
        @(negedge clk);
        drain(5);
        check("t6_after_wrap", 32'(bus.out_count), 32'h0001);
        check("t6_model", 32'(bus.out_count), 32'(exp_count));

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/multi_path_fanin_pipeline.md
# multi_path_fanin_pipeline

Registered fan-in counterpart to the combinational fan-out/reconverge stage tests: three independent valid/ready input lanes are merged by a round-robin arbiter into a single elastic pipeline of `STAGES` registers and delivered on one valid/ready output. It gives the path-analysis suite a sequential design with many start points converging on one end point, plus register-to-register and handshake paths, including the intentional `out_ready` → `in_ready` combinational path.

## Interface
- `WIDTH`, 8: data width of each lane and of the output.
- `STAGES`, 3: number of pipeline register stages; legal range 1..8.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 3: per-lane valid; bit k belongs to lane k.
- `in_data` input 3*WIDTH: lane k data occupies `[k*WIDTH +: WIDTH]`.
- `in_ready` output 3: per-lane ready; at most one bit high in any cycle.
- `out_valid` output 1: last stage holds an item.
- `out_data` output WIDTH: data of the last stage.
- `out_src` output 2: lane index (0..2) the item came from.
- `out_ready` input 1: downstream accepts when high together with `out_valid`.
- `out_count` output 16: number of completed output transfers, wraps modulo 2^16.

## Operation
- **Reset (rst_n low, asynchronous):**
  - All stage valid bits = 0.
  - `out_valid` = 0, `out_data` = 0, `out_src` = 0, `out_count` = 0.
  - Round-robin pointer = 0.
  - `in_ready` = 0 while reset is asserted.
- **Arbiter:** a round-robin search starts at the pointer and grants the first lane with `in_valid` high, in order ptr, ptr+1, ptr+2 (mod 3).
  - `in_ready[k]` = grant[k] AND stage 0 can accept.
  - Pointer updates only on an accepted transfer: it becomes (k+1) mod 3. Otherwise it is held.
  - A lane may drop `in_valid` without being accepted; no stickiness is required.
- **Stage s can accept** when it is empty, or when it will be emptied this cycle.
  - Last stage empties when `out_valid & out_ready`.
  - Stage s < STAGES-1 empties when stage s+1 can accept.
  - The full chain is combinational from `out_ready` back to `in_ready`. This path is intentional.
- **Advance and hold:**
  - Each stage captures {data, src} from the previous stage when it accepts. Stage 0 captures from the granted lane.
  - A stage holds its contents when it cannot pass them on.
  - Bubbles collapse: an empty stage ahead of an occupied stage is filled in the same cycle.
- **Capacity:** exactly `STAGES` items. When all stages are valid and `out_ready` is low, `in_ready` = 0.
- **Output stability:** while `out_valid` is high and `out_ready` is low, `out_data` and `out_src` are stable.
- **Empty stages:** data and src registers of empty stages keep their old values. Only the valid bits are architecturally meaningful, except that all registers are 0 after reset.
- **`out_count`:** increments by 1 on each `out_valid & out_ready` edge. 0xFFFF wraps to 0x0000.
- **Ordering:** items leave in acceptance order; the pipeline never reorders.

## Timing
- **Latency:** an input transfer in cycle t gives `out_valid` = 1 in cycle t+STAGES, provided the path is not stalled.
- **Throughput:** one item per cycle with `out_ready` held high, with any mix of lanes.
- **Simultaneous accept and deliver** on a full pipeline: allowed in the same cycle with no bubble.
- **Reset mid-operation:** every in-flight item is discarded immediately. `out_valid` falls asynchronously, with no output transfer counted.
  - First acceptance after reset release is at the first rising edge with `rst_n` high.
  - Arbitration after reset starts at lane 0.
- **Inputs:** no combinational path from `in_valid`/`in_data` to any output except `in_ready`.

## Test plan
1. **Single lane:** `STAGES`=3, only lane 1 valid with data 0x5A, `out_ready`=1 → `out_valid` in cycle t+3, `out_data`=0x5A, `out_src`=1, `out_count`=1.
2. **All lanes contend:** all three lanes valid continuously, `out_ready`=1 → grants go 0,1,2,0,1,2. Output `out_src` follows the same sequence at one item per cycle, starting 3 cycles after the first grant.
3. **Backpressure:**
   - Hold `out_ready`=0 and feed lane 2 with 0x01, 0x02, 0x03, 0x04 → 3 items accepted, then `in_ready`=0.
   - Output holds 0x01 stable.
   - Release `out_ready` → 0x01..0x04 delivered in order and `out_count`=4.
4. **Bubble collapse:** with 1 item stalled in the last stage, accept 2 more → the stages fill to 3 with no gaps. One cycle of `out_ready`=1 frees exactly one slot, and `in_ready` rises in that same cycle.
5. **Reset mid-flight:** 2 items in flight, then assert `rst_n`=0 for 2 cycles → `out_valid`=0 immediately and `out_count`=0. After release, lanes 0 and 2 both valid → lane 0 is granted first.
6. **Counter wrap:** force 65536 transfers → `out_count` returns to 0x0000 and continues to 0x0001 on the next transfer.
